ps_responder: RTL and testbench
===============================

# ps_responder

Synthesizable responder for the MMCM dynamic phase-shift handshake (psen/psdone) driven by the SRU phase-shift controller. It models the MMCM side of the port: it accepts a psen pulse, returns a one-cycle psdone a fixed latency later, and tracks the resulting phase position with wrap-around. It also produces a deserializer-word stand-in that shows the 16'hbc50 training word only while the phase is inside a programmable eye window. This closes the scan loop in simulation and in loop-back builds that have no real MMCM.

## Interface
- PS_LATENCY, 12, psclk cycles from the psen sample edge to psdone assertion; legal range 2..255.
- PHASE_STEPS, 1120, number of distinct phase positions; the phase counts 0..PHASE_STEPS-1 and wraps.
- TRAIN_WORD, 16'hbc50, word presented on deser_dout inside the eye.
- BAD_WORD, 16'hbc51, word presented on deser_dout outside the eye.

Ports:
- psclk  in  1  clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high.
- psen  in  1  phase-shift request, one-cycle pulse.
- psincdec  in  1  step direction, sampled with psen: 1 increments the phase, 0 decrements it.
- psdone  out  1  one-cycle completion pulse.
- ps_busy  out  1  high while a request is pending.
- phase  out  16  current phase position.
- eye_lo  in  16  first phase position inside the eye.
- eye_hi  in  16  last phase position inside the eye.
- deser_dout  out  16  simulated deserializer output.
- err_clr  in  1  clears ps_err.
- ps_err  out  1  sticky protocol-violation flag.

## Operation
- State machine with three states: IDLE, BUSY, DONE.
- IDLE
  - psen=1: latch psincdec, load the latency counter with PS_LATENCY-2, set ps_busy, go to BUSY.
- BUSY
  - Counter decrements by 1 each cycle.
  - At counter 0: go to DONE. On the same edge, assert psdone and update phase.
- DONE
  - Lasts one cycle; psdone=1 during it.
  - Next edge: psdone returns to 0, ps_busy returns to 0, state returns to IDLE.
- Phase update
  - Increment: PHASE_STEPS-1 wraps to 0.
  - Decrement: 0 wraps to PHASE_STEPS-1.
  - Arithmetic is 16-bit unsigned; no other change to phase.
- psen while BUSY or DONE: set ps_err, ignore the request. The pending operation is unaffected; no queueing.
- ps_err
  - Cleared by err_clr.
  - A violation in the same cycle as err_clr wins; ps_err stays 1.
- Eye test, evaluated on the registered phase
  - eye_lo <= eye_hi: inside when eye_lo <= phase <= eye_hi.
  - eye_lo > eye_hi (wrapped window): inside when phase >= eye_lo or phase <= eye_hi.
- deser_dout is registered each cycle: TRAIN_WORD when inside the eye, else BAD_WORD.

## Timing
- Reset values: psdone=0, ps_busy=0, phase=0, ps_err=0, deser_dout=16'h0000, state IDLE.
- Reset mid-operation aborts the pending request. No psdone is issued and the phase is not changed.
- psen sampled high at edge k:
  - ps_busy=1 from cycle k+1.
  - psdone=1 exactly in cycle k+PS_LATENCY.
  - The new phase is visible in that same cycle.
  - ps_busy=0 from cycle k+PS_LATENCY+1.
- deser_dout reflects the new phase in cycle k+PS_LATENCY+1. A controller that samples deser_dout one cycle after seeing psdone therefore sees the post-step word.
- Back-to-back requests: the earliest legal next psen is in cycle k+PS_LATENCY+1. Minimum request period is PS_LATENCY+1 cycles.
- psen in the DONE cycle is a violation (ps_err=1).
- eye_lo/eye_hi are quasi-static. A change takes effect on deser_dout one cycle later.

## Test plan
- Reset release, then single psen with psincdec=1 at edge 10 -> psdone high only in cycle 22, phase=1 in cycle 22, ps_busy high in cycles 11..22.
- phase=1119, increment -> phase=0. Then decrement -> phase=1119. Check both wraps.
- eye_lo=5, eye_hi=8, eight increments from 0:
  - deser_dout=16'hbc51 after steps 1..4.
  - deser_dout=16'hbc50 after steps 5..8.
  - Each value valid the cycle after psdone.
- Wrapped eye eye_lo=1118, eye_hi=2: phase 1119 and 1 -> 16'hbc50; phase 3 -> 16'hbc51.
- Second psen 4 cycles after the first -> ps_err=1, exactly one psdone, phase changes by 1. err_clr pulse -> ps_err=0.
- reset asserted 5 cycles after psen -> no psdone ever, phase stays 0. A fresh psen afterwards completes normally in 12 cycles.

Source files
------------

// File: rtl/ps_responder_if.sv
// ----------------------------------------------------------------------------
// ps_responder_if
// Dynamic phase-shift handshake between a phase-shift controller (master)
// and the MMCM-side responder (slave).
//   psen      : controller -> responder, one-cycle request pulse
//   psincdec  : controller -> responder, step direction (1 = increment)
//   psdone    : responder -> controller, one-cycle completion pulse
//   ps_busy   : responder -> controller, high while a request is pending
//   phase     : responder -> controller, current phase position
// ----------------------------------------------------------------------------
interface ps_responder_if;
    logic        psen;
    logic        psincdec;
    logic        psdone;
    logic        ps_busy;
    logic [15:0] phase;

    modport master (
        output psen,
        output psincdec,
        input  psdone,
        input  ps_busy,
        input  phase
    );

    modport slave (
        input  psen,
        input  psincdec,
        output psdone,
        output ps_busy,
        output phase
    );
endinterface

// File: rtl/ps_responder.sv
// ----------------------------------------------------------------------------
// ps_responder
// Stand-in for the MMCM side of the dynamic phase-shift port. Accepts a psen
// pulse, answers with a one-cycle psdone PS_LATENCY cycles later, and keeps a
// wrapping phase position. deser_dout presents TRAIN_WORD while the phase is
// inside the programmable eye window [eye_lo, eye_hi] (which may wrap past
// the top of the phase range), otherwise BAD_WORD.
//
// Ports:
//   psclk      in   clock, rising edge
//   reset      in   synchronous, active-high
//   ps         if   handshake (slave modport): psen, psincdec, psdone,
//                   ps_busy, phase
//   eye_lo     in   first phase position inside the eye
//   eye_hi     in   last phase position inside the eye
//   deser_dout out  simulated deserializer word (registered)
//   err_clr    in   clears ps_err
//   ps_err     out  sticky flag: psen seen while a request was pending
// ----------------------------------------------------------------------------
module ps_responder #(
    parameter int          PS_LATENCY  = 12,      // 2..255
    parameter int          PHASE_STEPS = 1120,
    parameter logic [15:0] TRAIN_WORD  = 16'hbc50,
    parameter logic [15:0] BAD_WORD    = 16'hbc51
) (
    input  logic          psclk,
    input  logic          reset,
    ps_responder_if.slave ps,
    input  logic [15:0]   eye_lo,
    input  logic [15:0]   eye_hi,
    output logic [15:0]   deser_dout,
    input  logic          err_clr,
    output logic          ps_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The load edge and the BUSY->DONE edge together account for two of the
    // PS_LATENCY cycles, hence the -2.
    localparam logic [7:0]  CNT_LOAD  = 8'(PS_LATENCY - 2);
    localparam logic [15:0] PHASE_MAX = 16'(PHASE_STEPS - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        dir_reg, dir_next;
    logic [15:0] phase_reg, phase_next;
    logic        err_reg, err_next;
    logic [15:0] dout_reg, dout_next;
    logic        in_eye;
    logic        violation;

    always_ff @(posedge psclk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            phase_reg <= '0;
            err_reg   <= 1'b0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            phase_reg <= phase_next;
            err_reg   <= err_next;
            dout_reg  <= dout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        phase_next = phase_reg;

        case (state_reg)
            IDLE: begin
                if (ps.psen) begin
                    dir_next   = ps.psincdec;
                    cnt_next   = CNT_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == 8'd0) begin
                    state_next = DONE;
                    // Phase changes on the same edge psdone rises, so the
                    // controller sees the new position together with psdone.
                    if (dir_reg) begin
                        phase_next = (phase_reg == PHASE_MAX) ? 16'd0 : phase_reg + 16'd1;
                    end else begin
                        phase_next = (phase_reg == 16'd0) ? PHASE_MAX : phase_reg - 16'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A request while one is pending is dropped; flag it. A new violation
    // outranks a simultaneous clear so no event is lost.
    assign violation = ps.psen && (state_reg != IDLE);

    always_comb begin
        err_next = violation | (err_reg & ~err_clr);
    end

    // Eye test on the registered phase; a window with eye_lo > eye_hi wraps
    // through the top of the phase range.
    always_comb begin
        in_eye = 1'b0;
        if (eye_lo <= eye_hi) begin
            in_eye = (phase_reg >= eye_lo) && (phase_reg <= eye_hi);
        end else begin
            in_eye = (phase_reg >= eye_lo) || (phase_reg <= eye_hi);
        end
        dout_next = in_eye ? TRAIN_WORD : BAD_WORD;
    end

    assign ps.psdone  = (state_reg == DONE);
    assign ps.ps_busy = (state_reg != IDLE);
    assign ps.phase   = phase_reg;
    assign deser_dout = dout_reg;
    assign ps_err     = err_reg;

endmodule

// File: tb/tb_ps_responder.sv
// ----------------------------------------------------------------------------
// tb_ps_responder
// Table of single-step vectors (direction, eye window, expected phase and
// deser word) plus hand-written sequences for protocol violations and
// reset abort. Expected phases are queued when psen is driven and popped by
// a monitor whenever psdone is seen.
//
// Timing convention: if psen is sampled at edge k, ps_busy is high from just
// after edge k, psdone is high only in the interval after edge k+L-1 (the
// "cycle k+L" of the responder's timing), and deser_dout shows the new word
// after edge k+L.
// ----------------------------------------------------------------------------
module tb_ps_responder;

    localparam int L = 12;

    logic        psclk = 1'b0;
    logic        reset = 1'b1;
    logic        err_clr = 1'b0;
    logic [15:0] eye_lo = 16'd0;
    logic [15:0] eye_hi = 16'd0;
    logic [15:0] deser_dout;
    logic        ps_err;

    ps_responder_if ps_bus ();

    ps_responder #(
        .PS_LATENCY (L),
        .PHASE_STEPS(1120),
        .TRAIN_WORD (16'hbc50),
        .BAD_WORD   (16'hbc51)
    ) dut (
        .psclk     (psclk),
        .reset     (reset),
        .ps        (ps_bus.slave),
        .eye_lo    (eye_lo),
        .eye_hi    (eye_hi),
        .deser_dout(deser_dout),
        .err_clr   (err_clr),
        .ps_err    (ps_err)
    );

    always #5 psclk = ~psclk;

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;

    typedef struct {
        bit          rst;
        bit          dir;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [15:0] ph;
        logic [15:0] dout;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitor: every psdone must match a queued request.
    always @(negedge psclk) begin
        if (!reset && ps_bus.psdone === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_psdone: psdone with phase %0d, expected no psdone", ps_bus.phase);
            end else begin
                mon_exp = sb.pop_front();
                chk("psdone_phase", {16'd0, ps_bus.phase}, {16'd0, mon_exp});
            end
        end
    end

    task automatic tick;
        @(posedge psclk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        chk("rst_psdone", ps_bus.psdone, 0);
        chk("rst_busy", ps_bus.ps_busy, 0);
        chk("rst_phase", ps_bus.phase, 0);
        chk("rst_err", ps_err, 0);
        chk("rst_dout", deser_dout, 16'h0000);
        reset = 1'b0;
        sb.delete();
    endtask

    // One legal request with full cycle-by-cycle timing check.
    task automatic step(input bit dir, input logic [15:0] exp_ph,
                        input logic [15:0] exp_dout, input string tag);
        int bad;
        int first_bad;
        bad = 0;
        first_bad = -1;
        sb.push_back(exp_ph);
        ps_bus.psen = 1'b1;
        ps_bus.psincdec = dir;
        tick;                               // after edge k
        ps_bus.psen = 1'b0;
        ps_bus.psincdec = ~dir;             // must not matter once sampled
        for (int i = 1; i <= L; i++) begin  // after edge k+i-1
            if (ps_bus.ps_busy !== 1'b1 || ps_bus.psdone !== (i == L)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            tick;
        end
        chk($sformatf("%s_timing_bad_cycles(first %0d)", tag, first_bad), bad, 0);
        chk($sformatf("%s_busy_end", tag), ps_bus.ps_busy, 0);
        chk($sformatf("%s_phase", tag), ps_bus.phase, exp_ph);
        chk($sformatf("%s_dout", tag), deser_dout, exp_dout);
    endtask

    int d0;

    initial begin
        ps_bus.psen = 1'b0;
        ps_bus.psincdec = 1'b0;

        //            rst   dir   lo       hi       phase    dout
        vt.push_back('{1'b1, 1'b1, 16'd5,    16'd8,    16'd1,    16'hbc51});
        vt.push_back('{1'b0, 1'b1, 16'd5,    16'd8,    16'd2,    16'hbc51});
        vt.push_back('{1'b0, 1'b1, 16'd5,    16'd8,    16'd3,    16'hbc51});
        vt.push_back('{1'b0, 1'b1, 16'd5,    16'd8,    16'd4,    16'hbc51});
        vt.push_back('{1'b0, 1'b1, 16'd5,    16'd8,    16'd5,    16'hbc50});
        vt.push_back('{1'b0, 1'b1, 16'd5,    16'd8,    16'd6,    16'hbc50});
        vt.push_back('{1'b0, 1'b1, 16'd5,    16'd8,    16'd7,    16'hbc50});
        vt.push_back('{1'b0, 1'b1, 16'd5,    16'd8,    16'd8,    16'hbc50});
        vt.push_back('{1'b1, 1'b0, 16'd1118, 16'd2,    16'd1119, 16'hbc50});
        vt.push_back('{1'b0, 1'b1, 16'd1118, 16'd2,    16'd0,    16'hbc50});
        vt.push_back('{1'b0, 1'b0, 16'd1118, 16'd2,    16'd1119, 16'hbc50});
        vt.push_back('{1'b0, 1'b1, 16'd1118, 16'd2,    16'd0,    16'hbc50});
        vt.push_back('{1'b0, 1'b1, 16'd1118, 16'd2,    16'd1,    16'hbc50});
        vt.push_back('{1'b0, 1'b1, 16'd1118, 16'd2,    16'd2,    16'hbc50});
        vt.push_back('{1'b0, 1'b1, 16'd1118, 16'd2,    16'd3,    16'hbc51});
        vt.push_back('{1'b0, 1'b0, 16'd1118, 16'd2,    16'd2,    16'hbc50});
        vt.push_back('{1'b1, 1'b0, 16'd1000, 16'd1118, 16'd1119, 16'hbc51});
        vt.push_back('{1'b0, 1'b0, 16'd1000, 16'd1118, 16'd1118, 16'hbc50});

        do_reset();

        // Back-to-back legal requests at the minimum period: no ps_err.
        for (int i = 0; i < vt.size(); i++) begin
            eye_lo = vt[i].lo;
            eye_hi = vt[i].hi;
            if (vt[i].rst) do_reset();
            step(vt[i].dir, vt[i].ph, vt[i].dout, $sformatf("vec%0d", i));
        end
        chk("no_err_after_table", ps_err, 0);

        // Second psen 4 cycles after the first: flagged, ignored.
        d0 = done_cnt;
        sb.push_back(16'd1119);
        ps_bus.psen = 1'b1;
        ps_bus.psincdec = 1'b1;
        tick;
        ps_bus.psen = 1'b0;
        repeat (3) tick;
        ps_bus.psen = 1'b1;
        tick;
        ps_bus.psen = 1'b0;
        chk("busy_violation_err", ps_err, 1);
        repeat (30) tick;
        chk("busy_violation_one_done", done_cnt - d0, 1);
        chk("busy_violation_phase", ps_bus.phase, 1119);
        chk("busy_violation_idle", ps_bus.ps_busy, 0);
        chk("err_sticky", ps_err, 1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_clr", ps_err, 0);

        // psen in the DONE cycle, together with err_clr: violation wins.
        d0 = done_cnt;
        sb.push_back(16'd0);
        ps_bus.psen = 1'b1;
        ps_bus.psincdec = 1'b1;
        tick;
        ps_bus.psen = 1'b0;
        repeat (L - 1) tick;
        chk("done_state_psdone", ps_bus.psdone, 1);
        ps_bus.psen = 1'b1;
        err_clr = 1'b1;
        tick;
        ps_bus.psen = 1'b0;
        err_clr = 1'b0;
        chk("done_violation_err_wins", ps_err, 1);
        chk("done_psen_ignored", ps_bus.ps_busy, 0);
        repeat (20) tick;
        chk("done_violation_one_done", done_cnt - d0, 1);
        chk("done_violation_phase", ps_bus.phase, 0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_clr2", ps_err, 0);

        // Reset five cycles after psen aborts the request.
        do_reset();
        d0 = done_cnt;
        sb.push_back(16'd1);
        ps_bus.psen = 1'b1;
        ps_bus.psincdec = 1'b1;
        tick;
        ps_bus.psen = 1'b0;
        repeat (4) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        sb.delete();
        repeat (20) tick;
        chk("abort_no_psdone", done_cnt - d0, 0);
        chk("abort_phase", ps_bus.phase, 0);
        chk("abort_busy", ps_bus.ps_busy, 0);
        step(1'b1, 16'd1, 16'hbc51, "fresh");

        chk("scoreboard_empty", sb.size(), 0);
        chk("final_err", ps_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
